// File: rtl/date_setter.sv
// date_setter: button-driven editor for a BCD date {DD,MM,YY}.
// Captures the running date, lets the user step day, month and year with
// inc/dec pulses, then asserts an overwrite request for two cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   set_btn, inc_btn, dec_btn single-cycle debounced button pulses
//   date_cur  [23:0]          running date in, BCD {DD,MM,YY}
//   date_in   [23:0]          edited date out (working registers)
//   date_mode [1:0]           0 run, 2 overwrite
//   editing                   high in any edit or commit state
//   edit_field [1:0]          0 none, 1 day, 2 month, 3 year
module date_setter (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic [23:0] date_cur,
  output logic [23:0] date_in,
  output logic [1:0]  date_mode,
  output logic        editing,
  output logic [1:0]  edit_field
);

  localparam int unsigned BW = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EDIT_DAY = 3'd1,
    EDIT_MON = 3'd2,
    EDIT_YR  = 3'd3,
    COMMIT1  = 3'd4,
    COMMIT2  = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [BW-1:0]   dd, mm, yy;
  logic [BW-1:0]   dd_d, mm_d, yy_d;
  logic [1:0]      mode_d, field_d;
  logic            editing_d;
  logic            step_up, step_dn;
  logic [BW-1:0]   mx;
  logic            day_ok, mon_ok, yr_ok;

  // Both digits in 0..9
  function automatic logic bcd_ok(input logic [BW-1:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] b);
    if (b[3:0] == 4'd9) return {4'(b[7:4] + 4'd1), 4'd0};
    return BW'(b + 8'd1);
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] b);
    if (b[3:0] == 4'd0) return {4'(b[7:4] - 4'd1), 4'd9};
    return BW'(b - 8'd1);
  endfunction

  // Divisible by 4 evaluated on BCD digits: parity of tens selects units set
  function automatic logic is_leap(input logic [BW-1:0] y);
    if (!y[4]) return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
  endfunction

  function automatic logic [BW-1:0] max_day(input logic [BW-1:0] m, input logic [BW-1:0] y);
    case (m)
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // Pull a day back into range after a month/year change
  function automatic logic [BW-1:0] clamp_day(input logic [BW-1:0] d, input logic [BW-1:0] lim);
    return (!bcd_ok(d) || (d > lim)) ? lim : d;
  endfunction

  // Field validity and simultaneous inc+dec cancellation
  always_comb begin
    step_up = inc_btn & ~dec_btn;
    step_dn = dec_btn & ~inc_btn;
    mx      = max_day(mm, yy);
    day_ok  = bcd_ok(dd) && (dd != 8'h00) && (dd <= mx);
    mon_ok  = bcd_ok(mm) && (mm != 8'h00) && (mm <= 8'h12);
    yr_ok   = bcd_ok(yy);
  end

  // Next state and working-register update
  always_comb begin
    state_d = state;
    dd_d    = dd;
    mm_d    = mm;
    yy_d    = yy;
    case (state)
      IDLE: begin
        if (set_btn) begin
          state_d           = EDIT_DAY;
          {dd_d, mm_d, yy_d} = date_cur;
        end
      end
      EDIT_DAY: begin
        if (set_btn) begin
          state_d = EDIT_MON;
        end else if (step_up) begin
          dd_d = (!day_ok || dd == mx) ? 8'h01 : bcd_inc(dd);
        end else if (step_dn) begin
          dd_d = (!day_ok || dd == 8'h01) ? mx : bcd_dec(dd);
        end
      end
      EDIT_MON: begin
        if (set_btn) begin
          state_d = EDIT_YR;
        end else if (step_up) begin
          mm_d = (!mon_ok || mm == 8'h12) ? 8'h01 : bcd_inc(mm);
          dd_d = clamp_day(dd, max_day(mm_d, yy));
        end else if (step_dn) begin
          mm_d = (!mon_ok || mm == 8'h01) ? 8'h12 : bcd_dec(mm);
          dd_d = clamp_day(dd, max_day(mm_d, yy));
        end
      end
      EDIT_YR: begin
        if (set_btn) begin
          state_d = COMMIT1;
          dd_d    = day_ok ? dd : mx;
        end else if (step_up) begin
          yy_d = (!yr_ok || yy == 8'h99) ? 8'h00 : bcd_inc(yy);
          dd_d = clamp_day(dd, max_day(mm, yy_d));
        end else if (step_dn) begin
          yy_d = (!yr_ok || yy == 8'h00) ? 8'h99 : bcd_dec(yy);
          dd_d = clamp_day(dd, max_day(mm, yy_d));
        end
      end
      COMMIT1: state_d = COMMIT2;
      COMMIT2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they register with it
  always_comb begin
    mode_d    = 2'd0;
    editing_d = 1'b0;
    field_d   = 2'd0;
    case (state_d)
      EDIT_DAY: begin editing_d = 1'b1; field_d = 2'd1; end
      EDIT_MON: begin editing_d = 1'b1; field_d = 2'd2; end
      EDIT_YR:  begin editing_d = 1'b1; field_d = 2'd3; end
      COMMIT1, COMMIT2: begin editing_d = 1'b1; mode_d = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dd         <= 8'h01;
      mm         <= 8'h01;
      yy         <= 8'h00;
      date_mode  <= 2'd0;
      editing    <= 1'b0;
      edit_field <= 2'd0;
    end else begin
      state      <= state_d;
      dd         <= dd_d;
      mm         <= mm_d;
      yy         <= yy_d;
      date_mode  <= mode_d;
      editing    <= editing_d;
      edit_field <= field_d;
    end
  end

  assign date_in = {dd, mm, yy};

endmodule

// File: tb/tb_date_setter.sv
// Scoreboard bench for date_setter: driver updates an integer-arithmetic
// reference model and queues expected outputs; a monitor compares them.
module tb_date_setter;

  logic        clk;
  logic        rst;
  logic        set_btn, inc_btn, dec_btn;
  logic [23:0] date_cur;
  logic [23:0] date_in;
  logic [1:0]  date_mode;
  logic        editing;
  logic [1:0]  edit_field;

  date_setter dut (
    .clk        (clk),
    .rst        (rst),
    .set_btn    (set_btn),
    .inc_btn    (inc_btn),
    .dec_btn    (dec_btn),
    .date_cur   (date_cur),
    .date_in    (date_in),
    .date_mode  (date_mode),
    .editing    (editing),
    .edit_field (edit_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] di;
    logic [1:0]  mode;
    logic        ed;
    logic [1:0]  fld;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: phase 0 idle, 1..3 editing day/month/year, 4..5 commit
  int        m_ph = 0;
  logic [7:0] m_d = 8'h01, m_m = 8'h01, m_y = 8'h00;

  function automatic int to_int(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic int days_in(input int mon, input int yr);
    if (mon == 2) return (yr >= 0 && yr % 4 == 0) ? 29 : 28;
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] fit_day(input logic [7:0] d, input int lim);
    int n;
    n = to_int(d);
    if (n < 0 || n > lim) return to_bcd(lim);
    return d;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit i, input bit d, input logic [23:0] cur);
    int dn, mn, yn, lim, dir;
    dir = (i && !d) ? 1 : ((d && !i) ? -1 : 0);
    if (r) begin
      m_ph = 0; m_d = 8'h01; m_m = 8'h01; m_y = 8'h00;
      return;
    end
    dn  = to_int(m_d);
    mn  = to_int(m_m);
    yn  = to_int(m_y);
    lim = days_in(mn, yn);
    case (m_ph)
      0: if (s) begin
           m_ph = 1; m_d = cur[23:16]; m_m = cur[15:8]; m_y = cur[7:0];
         end
      1, 2, 3: begin
        if (s) begin
          if (m_ph == 3 && (dn < 1 || dn > lim)) m_d = to_bcd(lim);
          m_ph = m_ph + 1;
        end else if (dir != 0) begin
          if (m_ph == 1) begin
            if (dn < 1 || dn > lim) dn = (dir > 0) ? 1 : lim;
            else dn = (dn + dir + lim - 1) % lim + 1;
            m_d = to_bcd(dn);
          end else if (m_ph == 2) begin
            if (mn < 1 || mn > 12) mn = (dir > 0) ? 1 : 12;
            else mn = (mn + dir + 11) % 12 + 1;
            m_m = to_bcd(mn);
            m_d = fit_day(m_d, days_in(mn, yn));
          end else begin
            if (yn < 0) yn = (dir > 0) ? 0 : 99;
            else yn = (yn + dir + 100) % 100;
            m_y = to_bcd(yn);
            m_d = fit_day(m_d, days_in(mn, yn));
          end
        end
      end
      4: m_ph = 5;
      default: m_ph = 0;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.di   = {m_d, m_m, m_y};
    e.mode = (m_ph >= 4) ? 2'd2 : 2'd0;
    e.ed   = (m_ph != 0);
    e.fld  = (m_ph >= 1 && m_ph <= 3) ? 2'(m_ph) : 2'd0;
    return e;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Drive one cycle of inputs; expectation is queued once the edge has taken it
  task automatic cyc(input bit r, input bit s, input bit i, input bit d);
    rst = r; set_btn = s; inc_btn = i; dec_btn = d;
    model_step(r, s, i, d, date_cur);
    @(posedge clk);
    q.push_back(model_out());
    #2;
  endtask

  function automatic logic [7:0] rnd_field(input int lo, input int hi);
    if ($urandom_range(0, 4) == 0) return 8'($urandom);
    return to_bcd(int'($urandom_range(hi, lo)));
  endfunction

  // Monitor: outputs are always valid, compare each queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("date_in",    date_in,           e.di);
        check("date_mode",  24'(date_mode),    24'(e.mode));
        check("editing",    24'(editing),      24'(e.ed));
        check("edit_field", 24'(edit_field),   24'(e.fld));
      end
    end
  end

  initial begin
    rst = 1'b1; set_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    date_cur = 24'h311204;
    #2;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);                      // inc ignored in IDLE
    // Day wrap 31 -> 01 and two-cycle commit
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    // Leap clamp via month, then via year
    date_cur = 24'h310104;
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // Month 01 dec -> 12, year 99 inc -> 00
    date_cur = 24'h019901;
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // Day 01 dec in April -> 30
    date_cur = 24'h010499;
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    // BCD 09 -> 10 on each field
    date_cur = 24'h090909;
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // set beats inc; inc+dec cancel; reset in EDIT_MON
    date_cur = 24'h150607;
    cyc(0, 1, 0, 0); cyc(0, 1, 1, 0); cyc(0, 0, 1, 1); cyc(1, 0, 0, 0);
    // Invalid captured fields, then reset during COMMIT1
    date_cur = 24'h3A1F07;
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    date_cur = 24'h002307;
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, s, i, d;
      if ($urandom_range(0, 7) == 0)
        date_cur = {rnd_field(1, 31), rnd_field(1, 12), to_bcd(int'($urandom_range(99, 0)))};
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 15);
      i = ($urandom_range(0, 99) < 35);
      d = ($urandom_range(0, 99) < 35);
      cyc(r, s, i, d);
    end
    rst = 1'b0; set_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("queue_drain", 24'(q.size()), 24'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/date_setter.md
DATE_SETTER -- requirements
Module: date_setter

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 set_btn  input  1  single-cycle debounced pulse; enter edit, advance field, or commit.
REQ-005 inc_btn  input  1  single-cycle debounced pulse; increment selected field.
REQ-006 dec_btn  input  1  single-cycle debounced pulse; decrement selected field.
REQ-007 date_cur  input  24  running date from datemodule date_out; BCD {DD[23:16],MM[15:8],YY[7:0]}.
REQ-008 date_in  output  24  date presented to datemodule date_in; same BCD packing.
REQ-009 date_mode  output  2  to datemodule date_mode; 2'd0 run, 2'd2 overwrite; 2'd1 and 2'd3 never driven.
REQ-010 editing  output  1  high in any edit or commit state.
REQ-011 edit_field  output  2  0 none, 1 day, 2 month, 3 year.

Function
REQ-012 FSM states: IDLE, EDIT_DAY, EDIT_MON, EDIT_YR, COMMIT1, COMMIT2.
REQ-013 IDLE + set_btn -> EDIT_DAY next cycle; working registers load date_cur on the same edge.
REQ-014 EDIT_DAY + set_btn -> EDIT_MON; EDIT_MON + set_btn -> EDIT_YR; EDIT_YR + set_btn -> COMMIT1.
REQ-015 COMMIT1 -> COMMIT2 -> IDLE unconditionally; all buttons ignored in COMMIT1/COMMIT2.
REQ-016 date_mode = 2'd2 in COMMIT1 and COMMIT2 (exactly 2 cycles); 2'd0 in all other states.
REQ-017 date_in = working registers in every state; holds last committed value while IDLE.
REQ-018 Priority in an edit state: set_btn beats inc/dec (inc/dec dropped that cycle); inc_btn and dec_btn together -> no change.
REQ-019 In IDLE, inc_btn/dec_btn have no effect.
REQ-020 Day range 01..max_day; inc at max -> 01; dec at 01 -> max_day.
REQ-021 Month range 01..12; inc 12 -> 01; dec 01 -> 12.
REQ-022 Year range 00..99; inc 99 -> 00; dec 00 -> 99.
REQ-023 All arithmetic in BCD: units 9 + 1 -> units 0, tens + 1; units 0 - 1 -> units 9, tens - 1.
REQ-024 max_day: month 02 -> 29 if leap else 28; months 04, 06, 09, 11 -> 30; else 31.
REQ-025 Leap = YY divisible by 4, computed on BCD: tens even with units in {0,4,8}, or tens odd with units in {2,6}; 00 is leap.
REQ-026 Any month or year change clamps day to new max_day in the same register update.
REQ-027 Invalid captured field (non-BCD digit, or out of range): inc -> field minimum, dec -> field maximum.
REQ-028 Invalid captured day also clamped to max_day on entering COMMIT1.
REQ-029 Each accepted button pulse changes a field by exactly one step; result visible on date_in the next cycle.
REQ-030 edit_field and editing are registered with the state: IDLE 0/0; EDIT_DAY 1/1; EDIT_MON 2/1; EDIT_YR 3/1; COMMIT1/2 0/1.

Reset
REQ-031 rst high at a clock edge -> state IDLE, working registers 24'h010100, date_in 24'h010100, date_mode 2'd0, editing 0, edit_field 0.
REQ-032 rst overrides all inputs and aborts any edit or commit in progress; a reset during COMMIT1 shortens date_mode = 2'd2 to the cycles before reset.

Verification
REQ-033 date_cur=24'h311204; set, inc -> EDIT_DAY, date_in 24'h011204; set, set, set -> COMMIT1/2, date_mode 2'd2 for exactly 2 cycles, then 0.
REQ-034 date_cur=24'h310104; set, set (EDIT_MON), inc -> date_in 24'h290204 (leap clamp); then set, inc (YY 05) -> 24'h280205.
REQ-035 Year 99 inc -> 00; month 01 dec -> 12; day 01 dec in month 04 -> 30; BCD 09 inc -> 10 on each field.
REQ-036 Edit state, set_btn+inc_btn in the same cycle -> field advances, value unchanged; inc_btn+dec_btn together -> no change.
REQ-037 rst asserted in EDIT_MON -> next cycle IDLE, date_in 24'h010100, date_mode 0, editing 0.
REQ-038 Loopback with datemodule: commit 24'h311204 at hour 03, then hour 23 -> 00 -> datemodule date_out 24'h010105.
